// File: rtl/ahb_timer_slave.sv
// AHB-lite responder for the timer window: 32-bit down-counter, prescaler, auto-reload, level irq.
// Latency: WAIT_STATES stall cycles plus one DONE cycle per OKAY beat; errors take ERR1 then ERR2.
// Backpressure: PREADY low in WAIT/ERR1; a new address phase is only sampled while PREADY is high.
module ahb_timer_slave #(
  parameter logic [15:0] BASE_HI     = 16'h1000,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned PRESC_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic [1:0]  PSIZE,
  input  logic [1:0]  PTRANS,
  input  logic [2:0]  PBURST,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PRESP,
  output logic        irq
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t state, state_nxt;
  logic [2:0] wcnt, wcnt_nxt;
  logic [4:0] a_off;
  logic       a_wr;
  logic       sel, legal;

  logic               en, ar, ie, tif;
  logic [31:0]        load, value;
  logic [PRESC_W-1:0] presc, pc;
  logic               tick, expire;
  logic               wr_en, wr_ctrl, wr_load, wr_value, wr_status, wr_presc;
  logic [31:0]        rd_mux;

  logic unused_ok;
  assign unused_ok = ^{PBURST, PTRANS[0]};

  assign sel   = PTRANS[1] && (PADDR[31:16] == BASE_HI);
  assign legal = (PSIZE == 2'b10) && (PADDR[1:0] == 2'b00) &&
                 (PADDR[15:5] == 11'd0) && (PADDR[4:0] <= 5'h10);

  assign PREADY = !((state == S_WAIT) || (state == S_ERR1));
  assign PRESP  = (state == S_ERR1) || (state == S_ERR2);

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      S_WAIT: begin
        if (wcnt <= 3'd1) state_nxt = S_DONE;
        else              wcnt_nxt  = wcnt - 3'd1;
      end
      S_ERR1: state_nxt = S_ERR2;
      default: begin
        // IDLE, DONE and ERR2 all have PREADY high, so each may accept the next beat
        state_nxt = S_IDLE;
        if (sel) begin
          if (!legal)       state_nxt = S_ERR1;
          else if (WS == 0) state_nxt = S_DONE;
          else begin
            state_nxt = S_WAIT;
            wcnt_nxt  = WS;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      wcnt  <= 3'd0;
      a_off <= 5'd0;
      a_wr  <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (PREADY && sel) begin
        a_off <= PADDR[4:0];
        a_wr  <= PWRITE;
      end
    end
  end

  assign wr_en     = (state == S_DONE) && a_wr;
  assign wr_ctrl   = wr_en && (a_off == 5'h00);
  assign wr_load   = wr_en && (a_off == 5'h04);
  assign wr_value  = wr_en && (a_off == 5'h08);
  assign wr_status = wr_en && (a_off == 5'h0C);
  assign wr_presc  = wr_en && (a_off == 5'h10);

  assign tick   = en && (pc == presc);
  assign expire = tick && (value == 32'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en    <= 1'b0;
      ar    <= 1'b0;
      ie    <= 1'b0;
      tif   <= 1'b0;
      load  <= 32'd0;
      value <= 32'd0;
      presc <= '0;
      pc    <= '0;
      irq   <= 1'b0;
    end else begin
      pc <= (!en || tick) ? '0 : pc + 1'b1;
      if (wr_ctrl) begin
        ar <= PWDATA[1];
        ie <= PWDATA[2];
      end
      if (wr_ctrl)            en <= PWDATA[0];
      else if (expire && !ar) en <= 1'b0;
      if (wr_load) load <= PWDATA;
      // bus write to VALUE takes priority over the counter
      if (wr_value)  value <= PWDATA;
      else if (tick) value <= (value != 32'd0) ? value - 32'd1 : (ar ? load : value);
      if (expire)                      tif <= 1'b1;
      else if (wr_status && PWDATA[0]) tif <= 1'b0;
      if (wr_presc) presc <= PWDATA[PRESC_W-1:0];
      irq <= tif & ie;
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (a_off)
      5'h00:   rd_mux = {29'd0, ie, ar, en};
      5'h04:   rd_mux = load;
      5'h08:   rd_mux = value;
      5'h0C:   rd_mux = {31'd0, tif};
      5'h10:   rd_mux = 32'(presc);
      default: rd_mux = 32'd0;
    endcase
  end

  assign PRDATA = ((state == S_DONE) && !a_wr) ? rd_mux : 32'd0;

endmodule

// File: tb/tb_ahb_timer_slave.sv
// Directed bench for ahb_timer_slave: pipelined bus driver, expected-response queue, timer timing checks.
module tb_ahb_timer_slave;

  localparam logic [15:0] BASE = 16'h1000;
  localparam int          WS   = 1;

  localparam logic [31:0] A_CTRL   = 32'h1000_0000;
  localparam logic [31:0] A_LOAD   = 32'h1000_0004;
  localparam logic [31:0] A_VALUE  = 32'h1000_0008;
  localparam logic [31:0] A_STATUS = 32'h1000_000C;
  localparam logic [31:0] A_PRESC  = 32'h1000_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PADDR  = 32'd0;
  logic        PWRITE = 1'b0;
  logic [1:0]  PSIZE  = 2'b10;
  logic [1:0]  PTRANS = 2'b00;
  logic [2:0]  PBURST = 3'b000;
  logic [31:0] PWDATA = 32'd0;
  logic [31:0] PRDATA;
  logic        PREADY, PRESP, irq;

  always #5 clk = ~clk;

  ahb_timer_slave #(.BASE_HI(BASE), .WAIT_STATES(WS), .PRESC_W(16)) dut (
    .clk(clk), .rst(rst), .PADDR(PADDR), .PWRITE(PWRITE), .PSIZE(PSIZE),
    .PTRANS(PTRANS), .PBURST(PBURST), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PRESP(PRESP), .irq(irq)
  );

  typedef struct {
    logic        chk_rd;
    logic [31:0] rdata;
    logic        resp;
    int          waits;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_cap = 0;
  bit   dp_open  = 1'b0;
  int   wcnt     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Drives one address phase (caller sits at posedge+1); data phase is checked by the monitor
  task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] sz,
                       input logic [31:0] wd, input logic [31:0] erd, input logic eresp);
    exp_t e;
    int n = 0;
    while (PREADY !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("issue_ready", {31'd0, PREADY}, 32'd1);
    PADDR  = a;
    PWRITE = w;
    PSIZE  = sz;
    PTRANS = 2'b10;
    e.chk_rd = !w || eresp;
    e.rdata  = erd;
    e.resp   = eresp;
    e.waits  = eresp ? 1 : WS;
    exp_q.push_back(e);
    @(posedge clk); #1;
    last_cap = cyc;
    PTRANS = 2'b00;
    PWDATA = wd;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    issue(a, 1'b1, 2'b10, d, 32'd0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d);
    issue(a, 1'b0, 2'b10, 32'd0, d, 1'b0);
  endtask

  // Data-phase monitor: pops one expectation per completed beat
  always @(negedge clk) begin
    if (!rst) begin
      dp_open = 1'b0;
      wcnt    = 0;
      exp_q.delete();
    end else begin
      if (dp_open) begin
        if (PREADY !== 1'b1) begin
          wcnt++;
          if (exp_q.size() != 0) chk("resp_stall", {31'd0, PRESP}, {31'd0, exp_q[0].resp});
        end else begin
          chk("dp_queue_nonempty", {31'd0, (exp_q.size() != 0)}, 32'd1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("resp_done", {31'd0, PRESP}, {31'd0, cur.resp});
            chk("wait_cycles", wcnt, cur.waits);
            if (cur.chk_rd) chk("prdata", PRDATA, cur.rdata);
          end
          dp_open = 1'b0;
          wcnt    = 0;
        end
      end
      if (PREADY === 1'b1 && PTRANS[1] && PADDR[31:16] == BASE) dp_open = 1'b1;
    end
  end

  int cap_a, cap_b;

  initial begin
    // reset values
    #2 rst = 1'b0;
    #2;
    chk("rst_pready", {31'd0, PREADY}, 32'd1);
    chk("rst_presp",  {31'd0, PRESP},  32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_irq",    {31'd0, irq},    32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // LOAD write and readback
    wr(A_LOAD, 32'h0000_0064);
    rd(A_LOAD, 32'h0000_0064);
    rd(A_STATUS, 32'd0);

    // writes then back-to-back reads; unused PRESC bits read zero
    wr(A_VALUE, 32'h0000_0055);
    wr(A_PRESC, 32'h1234_0ABC);
    rd(A_CTRL, 32'd0);
    cap_a = last_cap;
    rd(A_VALUE, 32'h0000_0055);
    cap_b = last_cap;
    chk("b2b_gap", cap_b - cap_a, 2);
    rd(A_PRESC, 32'h0000_0ABC);

    // error responses, no register side effects
    issue(32'h1000_0014, 1'b0, 2'b10, 32'd0, 32'd0, 1'b1);
    issue(A_CTRL,        1'b1, 2'b00, 32'h7, 32'd0, 1'b1);
    issue(32'h1000_0006, 1'b0, 2'b10, 32'd0, 32'd0, 1'b1);
    issue(32'h1000_0104, 1'b1, 2'b10, 32'hFF, 32'd0, 1'b1);
    rd(A_CTRL, 32'd0);
    rd(A_LOAD, 32'h0000_0064);

    // auto-reload timer: PRESC=1 -> a tick every 2 clocks
    wr(A_PRESC, 32'd1);
    wr(A_LOAD,  32'd3);
    wr(A_VALUE, 32'd3);
    wr(A_CTRL,  32'h7);
    rd(A_VALUE, 32'd3);
    rd(A_VALUE, 32'd2);
    rd(A_VALUE, 32'd1);
    rd(A_VALUE, 32'd0);
    rd(A_VALUE, 32'd3);
    chk("irq_lags_tif", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("irq_rise", {31'd0, irq}, 32'd1);
    rd(A_STATUS, 32'd1);

    // stop, clear TIF
    wr(A_CTRL,   32'd0);
    wr(A_STATUS, 32'd1);
    rd(A_STATUS, 32'd0);
    chk("irq_after_clear", {31'd0, irq}, 32'd0);

    // one-shot expiry with W1C colliding with the TIF set
    wr(A_VALUE,  32'd0);
    wr(A_PRESC,  32'd1);
    wr(A_CTRL,   32'h5);
    wr(A_STATUS, 32'd1);
    rd(A_STATUS, 32'd1);
    rd(A_CTRL,   32'h4);
    rd(A_VALUE,  32'd0);
    chk("irq_oneshot", {31'd0, irq}, 32'd1);

    // reset during the WAIT of a VALUE write
    issue(A_VALUE, 1'b1, 2'b10, 32'h77, 32'd0, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("midrst_pready", {31'd0, PREADY}, 32'd1);
    chk("midrst_presp",  {31'd0, PRESP},  32'd0);
    chk("midrst_irq",    {31'd0, irq},    32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    rd(A_VALUE,  32'd0);
    rd(A_STATUS, 32'd0);
    rd(A_CTRL,   32'd0);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
